usr_seq_ctrl: RTL

- Command sequencer for the existing 4-bit universal shift register (S/I/SIL/SIR/Out datapath).
- Accepts one command at a time over a valid/ready interface: READ, LOAD, logical, rotate or arithmetic shift by N.
- Drives the register's mode and serial-in pins cycle by cycle, then returns the register contents over a valid/ready response channel.
- Sits between a bus/host and the shift register; the register itself stays external.

---
 rtl/usr_ctrl_pkg.sv | 30 +++
 rtl/usr_fill_sel.sv | 43 ++++
 rtl/usr_seq_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/usr_ctrl_pkg.sv
// Shared encodings for the universal-shift-register command sequencer:
// opcodes, register mode pins and controller FSM states.
package usr_ctrl_pkg;

  localparam logic [2:0] OP_READ = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
           (op == OP_ROR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/usr_fill_sel.sv
// Mode and serial-fill selection for the shift register while a command
// is actively executing; everything idles at hold with zero fills otherwise.
module usr_fill_sel
  import usr_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             active_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] sr_q_i,
  output logic [1:0]       sr_s_o,
  output logic             sil_o,
  output logic             sir_o
);

  always_comb begin
    sr_s_o = MODE_HOLD;
    sil_o  = 1'b0;
    sir_o  = 1'b0;
    if (active_i) begin
      case (op_i)
        OP_LOAD: sr_s_o = MODE_LOAD;
        OP_SHL:  sr_s_o = MODE_SHL;
        OP_SHR:  sr_s_o = MODE_SHR;
        OP_ROL: begin
          sr_s_o = MODE_SHL;
          sil_o  = sr_q_i[WIDTH-1];
        end
        OP_ROR: begin
          sr_s_o = MODE_SHR;
          sir_o  = sr_q_i[0];
        end
        // Sign bit re-enters at the MSB so the value keeps its sign.
        OP_ASR: begin
          sr_s_o = MODE_SHR;
          sir_o  = sr_q_i[WIDTH-1];
        end
        default: sr_s_o = MODE_HOLD;
      endcase
    end
  end

endmodule

// File: rtl/usr_seq_ctrl.sv
// Command sequencer for an external universal shift register. Optional
// EXEC abort (abort / rsp_aborted ports) is enabled by USR_SEQ_CTRL_ABORT_EN.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid holds its payload until then, ready may drop any cycle.
module usr_seq_ctrl
  import usr_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       sr_s,
  output logic [WIDTH-1:0] sr_i,
  output logic             sr_sil,
  output logic             sr_sir,
  input  logic [WIDTH-1:0] sr_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
`ifdef USR_SEQ_CTRL_ABORT_EN
  input  logic             abort,
  output logic             rsp_aborted,
`endif
  output logic             busy,
  output state_t           state_dbg
);

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             accept;
  logic             abort_hit;
  logic             exec_active;

  assign cmd_ready   = (state_q == ST_IDLE) && !clear;
  assign accept      = cmd_valid && cmd_ready;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_data    = sr_q;
  assign busy        = (state_q != ST_IDLE);
  assign state_dbg   = state_q;

`ifdef USR_SEQ_CTRL_ABORT_EN
  logic aborted_q;

  assign abort_hit   = (state_q == ST_EXEC) && abort;
  assign rsp_aborted = aborted_q;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      aborted_q <= 1'b0;
    end else if (accept) begin
      aborted_q <= 1'b0;
    end else if (abort_hit) begin
      aborted_q <= 1'b1;
    end
  end
`else
  assign abort_hit   = 1'b0;
`endif

  // An aborted EXEC cycle holds the register, so nothing is driven then.
  assign exec_active = (state_q == ST_EXEC) && !abort_hit;
  assign sr_i        = (exec_active && (op_q == OP_LOAD)) ? data_q : '0;

  usr_fill_sel #(
    .WIDTH(WIDTH)
  ) u_fill_sel (
    .active_i(exec_active),
    .op_i    (op_q),
    .sr_q_i  (sr_q),
    .sr_s_o  (sr_s),
    .sil_o   (sr_sil),
    .sir_o   (sr_sir)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = cmd_op;
          cnt_d  = cmd_cnt;
          data_d = cmd_data;
          if ((cmd_op == OP_LOAD) || (is_shift_op(cmd_op) && (cmd_cnt != '0))) begin
            state_d = ST_EXEC;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        if (abort_hit || (op_q == OP_LOAD)) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
